// File: rtl/mant_mul_seq.sv
// Sequential unsigned MANT_W x MANT_W mantissa multiplier (shift-add, one op in flight).
// Define MANT_MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle using a precomputed 3M.
module mant_mul_seq #(
  parameter int MANT_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     a_mant,
  input  logic [MANT_W-1:0]     b_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   prod,
  output logic                  ovf
);

  localparam int PW = 2 * MANT_W;
`ifdef MANT_MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int ITERS = MANT_W / STEP;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int SW    = MANT_W + STEP;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

`ifdef MANT_MUL_RADIX4_EN
  if (MANT_W % 2 != 0) begin : g_odd_width
    $error("mant_mul_seq: MANT_W must be even when MANT_MUL_RADIX4_EN is defined");
  end
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [MANT_W-1:0]   mcand_q, mcand_d;
  logic [MANT_W-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [SW-1:0]       pp;
  logic [SW-1:0]       sum;
  logic [PW-1:0]       acc_next;

`ifdef MANT_MUL_RADIX4_EN
  logic [MANT_W+1:0]   m3_q, m3_d;

  always_comb begin
    case (mplier_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = SW'(mcand_q);
      2'd2:    pp = SW'({mcand_q, 1'b0});
      default: pp = m3_q;
    endcase
  end
`else
  always_comb begin
    pp = mplier_q[0] ? SW'(mcand_q) : '0;
  end
`endif

  // Partial product lands on the upper half; the sum's low bits fall into the lower half on shift.
  always_comb begin
    sum      = SW'(acc_q[PW-1:MANT_W]) + pp;
    acc_next = {sum, acc_q[MANT_W-1:STEP]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`ifdef MANT_MUL_RADIX4_EN
    m3_d     = m3_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mant;
          mplier_d = b_mant;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MANT_MUL_RADIX4_EN
          m3_d     = (MANT_W+2)'(a_mant) + (MANT_W+2)'({a_mant, 1'b0});
`endif
          if (a_mant == '0 || b_mant == '0) begin
            prod_d  = '0;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          prod_d  = acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef MANT_MUL_RADIX4_EN
      m3_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef MANT_MUL_RADIX4_EN
      m3_q        <= m3_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign ovf       = prod_q[PW-1];

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: directed cases, backpressure, reset abort, random traffic.
// Honours MANT_MUL_RADIX4_EN for the expected BUSY latency.
module tb_mant_mul_seq;
  localparam int W = 24;
`ifdef MANT_MUL_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif
  localparam int NRND = 1500;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_mant;
  logic [W-1:0]   b_mant;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           ovf;

  int total = 0;
  int bad   = 0;

  mant_mul_seq #(.MANT_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_mant(a_mant), .b_mant(b_mant), .out_valid(out_valid),
    .out_ready(out_ready), .prod(prod), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents one pair, returns cycles from accept edge to out_valid (-1 on timeout).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int n;
    lat = -1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    a_mant = a;
    b_mant = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp_p, input logic exp_o, input int exp_lat);
    int lat;
    start_op(a, b, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_prod"}, 64'(prod), exp_p);
    check({tag, "_ref"}, 64'(prod), ref_mul(a, b));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
    release_op();
    check({tag, "_ovld_low"}, 64'(out_valid), 64'd0);
    check({tag, "_irdy_high"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int            lat;
    logic [63:0]   bp_exp;
    logic [63:0]   exp_q[$];
    logic [63:0]   e;
    logic [W-1:0]  ra, rb;
    logic          acc_s, hs_s;
    logic [2*W-1:0] prod_s;
    logic          ovf_s;
    int            sent, recv, cyc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_mant = '0; b_mant = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk) reset = 1'b0;

    run_dir("one_one", 24'h800000, 24'h800000, 64'h4000_0000_0000, 1'b0, LAT);
    run_dir("half_half", 24'hC00000, 24'hC00000, 64'h9000_0000_0000, 1'b1, LAT);
    run_dir("max_max", 24'hFFFFFF, 24'hFFFFFF, 64'hFFFF_FE00_0001, 1'b1, LAT);
    run_dir("zero_a", 24'h000000, 24'hABCDEF, 64'h0, 1'b0, 1);
    run_dir("zero_b", 24'hABCDEF, 24'h000000, 64'h0, 1'b0, 1);
    run_dir("denorm", 24'h000003, 24'h000005, 64'hF, 1'b0, LAT);

    // Backpressure: result held, no new accepts while out_ready stays low.
    bp_exp = ref_mul(24'h9A5B3C, 24'h77E1F0);
    start_op(24'h9A5B3C, 24'h77E1F0, lat);
    check("bp_lat", 64'(lat), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a_mant = W'($urandom);
      b_mant = W'($urandom);
      @(posedge clk);
      #1;
      check("bp_prod", 64'(prod), bp_exp);
      check("bp_ovf", 64'(ovf), 64'(bp_exp[2*W-1]));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk) in_valid = 1'b0;
    release_op();
    check("bp_rel_in_ready", 64'(in_ready), 64'd1);
    check("bp_rel_out_valid", 64'(out_valid), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("bp_no_ghost", 64'(out_valid), 64'd0);
    end

    // Reset during BUSY discards the in-flight operation.
    @(negedge clk);
    a_mant = 24'hABCDEF; b_mant = 24'h123457; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) reset = 1'b0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1 check("abort_no_result", 64'(out_valid), 64'd0);
    end
    run_dir("post_abort", 24'h800001, 24'h800001, 64'h4000_0100_0001, 1'b0, LAT);

    // Random back-to-back traffic with random out_ready.
    sent = 0; recv = 0; cyc = 0;
    while ((sent < NRND || recv < NRND) && cyc < 90000) begin
      @(negedge clk);
      if (!in_valid && sent < NRND) begin
        ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
        rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
        a_mant = ra;
        b_mant = rb;
        in_valid = 1'b1;
      end
      out_ready = $urandom_range(0, 1) == 1;
      acc_s  = in_valid && in_ready;
      hs_s   = out_valid && out_ready;
      prod_s = prod;
      ovf_s  = ovf;
      @(posedge clk);
      if (acc_s) begin
        exp_q.push_back(ref_mul(a_mant, b_mant));
        sent++;
      end
      if (hs_s) begin
        recv++;
        if (exp_q.size() == 0) begin
          check("rnd_extra_result", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("rnd_prod", 64'(prod_s), e);
          check("rnd_ovf", 64'(ovf_s), 64'(e[2*W-1]));
        end
      end
      #1;
      if (acc_s) in_valid = 1'b0;
      cyc++;
    end
    @(negedge clk) out_ready = 1'b0;
    check("rnd_sent", 64'(sent), 64'(NRND));
    check("rnd_recv", 64'(recv), 64'(NRND));
    check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
